stage_mem_access: RTL and testbench

STAGE_MEM_ACCESS -- requirements
Module: stage_mem_access

---
 rtl/mem_pkg.sv | 38 +++
 rtl/stage_mem_access_if.sv | 16 +
 rtl/load_align.sv | 23 ++
 rtl/stage_mem_access.sv | 135 +++++++++++++
 tb/tb_stage_mem_access.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states and the
// latched context of an outstanding load.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } ma_state_e;

  localparam int BE_W = 4;

  // Everything needed to turn the returned word into write-back data.
  typedef struct packed {
    mem_size_e  size;
    logic       sign;
    logic [1:0] off;
    logic       load;
    logic       reg_wen;
  } ld_ctx_t;

  // Reserved size behaves as a word access.
  function automatic logic misaligned(input mem_size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/stage_mem_access_if.sv
// Data-memory request/response bus between the MEM stage and the memory.
interface stage_mem_access_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    req;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] be;
  logic                    ack;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/load_align.sv
// Extracts the addressed byte/half from a memory word and extends it.
module load_align import mem_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  mem_size_e             size,
  input  logic [1:0]            offset,
  input  logic                  sign,
  output logic [DATA_WIDTH-1:0] data
);
  logic [DATA_WIDTH-1:0] sh;

  assign sh = rdata >> {offset, 3'b000};

  always_comb begin
    data = sh;
    case (size)
      SZ_BYTE: data = {{(DATA_WIDTH-8){sign & sh[7]}}, sh[7:0]};
      SZ_HALF: data = {{(DATA_WIDTH-16){sign & sh[15]}}, sh[15:0]};
      default: data = sh;
    endcase
  end
endmodule

// File: rtl/stage_mem_access.sv
// MEM pipeline stage: passes ALU results through and runs loads/stores over
// an ack-based memory bus, stalling upstream while an access is in flight.
module stage_mem_access import mem_pkg::*; #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  input  logic                      in_mem_read,
  input  logic                      in_mem_write,
  input  logic [1:0]                in_size,
  input  logic                      in_signed,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  input  logic [DATA_WIDTH-1:0]     in_store_data,
  input  logic                      in_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
  output logic                      stall_out,
  stage_mem_access_if.master        dm,
  output logic                      wb_wen,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
  output logic [DATA_WIDTH-1:0]     wb_wdata,
  output logic                      err_misalign
);
  localparam int BEW = DATA_WIDTH / 8;

  ma_state_e                 state, state_nxt;
  mem_size_e                 size;
  logic                      mem_op, bad, accept;
  logic [DATA_WIDTH-1:0]     st_wdata, ld_data;
  logic [BEW-1:0]            st_be;
  ld_ctx_t                   ctx;
  logic [REG_ADDR_WIDTH-1:0] rd_q;

  assign size   = mem_size_e'(in_size);
  assign mem_op = in_mem_read | in_mem_write;
  assign bad    = misaligned(size, in_addr[1:0]);
  assign accept = (state == ST_IDLE) && in_valid && mem_op && !bad;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    stall_out = 1'b0;
    case (state)
      ST_IDLE: if (accept) begin
        state_nxt = ST_REQ;
        stall_out = 1'b1;
      end
      ST_REQ: begin
        stall_out = 1'b1;
        if (dm.ack) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Store lane replication and byte enables; also drives be for loads.
  always_comb begin
    st_wdata = in_store_data;
    st_be    = '1;
    case (size)
      SZ_BYTE: begin
        st_wdata = {BEW{in_store_data[7:0]}};
        st_be    = BEW'(1) << in_addr[1:0];
      end
      SZ_HALF: begin
        st_wdata = {(BEW/2){in_store_data[15:0]}};
        st_be    = BEW'(3) << in_addr[1:0];
      end
      default: ;
    endcase
  end

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .rdata  (dm.rdata),
    .size   (ctx.size),
    .offset (ctx.off),
    .sign   (ctx.sign),
    .data   (ld_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dm.req       <= 1'b0;
      dm.we        <= 1'b0;
      dm.addr      <= '0;
      dm.wdata     <= '0;
      dm.be        <= '0;
      ctx          <= '0;
      rd_q         <= '0;
      wb_wen       <= 1'b0;
      wb_rd_addr   <= '0;
      wb_wdata     <= '0;
      err_misalign <= 1'b0;
    end else begin
      err_misalign <= 1'b0;
      wb_wen       <= 1'b0;
      case (state)
        ST_IDLE: if (in_valid) begin
          if (!mem_op) begin
            wb_wen     <= in_reg_wen;
            wb_rd_addr <= in_rd_addr;
            wb_wdata   <= DATA_WIDTH'(in_addr);
          end else if (bad) begin
            err_misalign <= 1'b1;
          end else begin
            dm.req   <= 1'b1;
            dm.we    <= in_mem_write;
            dm.addr  <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
            dm.wdata <= st_wdata;
            dm.be    <= st_be;
            // write wins when both read and write are requested
            ctx      <= '{size, in_signed, in_addr[1:0], !in_mem_write, in_reg_wen};
            rd_q     <= in_rd_addr;
          end
        end
        ST_REQ: if (dm.ack) begin
          dm.req <= 1'b0;
          dm.we  <= 1'b0;
          if (ctx.load) begin
            wb_wen     <= ctx.reg_wen;
            wb_rd_addr <= rd_q;
            wb_wdata   <= ld_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_stage_mem_access.sv
// Bench for stage_mem_access: directed scenarios plus randomized ops checked
// against an arithmetic reference of the load/store rules.
module tb_stage_mem_access;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_mem_read, in_mem_write, in_signed, in_reg_wen;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_store_data;
  logic [3:0]  in_rd_addr;
  logic        stall_out, wb_wen, err_misalign;
  logic [3:0]  wb_rd_addr;
  logic [31:0] wb_wdata;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stage_mem_access_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dm_bus ();

  stage_mem_access #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_size(in_size), .in_signed(in_signed),
    .in_addr(in_addr), .in_store_data(in_store_data), .in_reg_wen(in_reg_wen),
    .in_rd_addr(in_rd_addr), .stall_out(stall_out), .dm(dm_bus), .wb_wen(wb_wen),
    .wb_rd_addr(wb_rd_addr), .wb_wdata(wb_wdata), .err_misalign(err_misalign)
  );

  typedef struct {
    int          stalls;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          stable;
    logic        wen;
    logic [31:0] wdat;
    logic [3:0]  rda;
    logic        done_stall;
    logic        done_req;
    logic        wen_after;
    int          errs;
    bit          req_seen;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic longint nbytes(logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_mis(logic [1:0] sz, logic [31:0] a);
    return (longint'(a) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(logic [1:0] sz, bit sgn, logic [31:0] a, logic [31:0] rd);
    longint n = nbytes(sz);
    longint off = longint'(a) % 4;
    longint span = longint'(1) << (8 * n);
    longint v = (longint'(rd) / (longint'(1) << (8 * off))) % span;
    if (sgn && n < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_be(logic [1:0] sz, logic [31:0] a);
    longint n = nbytes(sz);
    longint be = (n == 4) ? 15 : (((longint'(1) << n) - 1) << (longint'(a) % 4));
    return be[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(logic [1:0] sz, logic [31:0] d);
    longint n = nbytes(sz);
    longint v = longint'(d);
    if (n == 1) v = (v % 256) * 64'h0101_0101;
    else if (n == 2) v = (v % 65536) * 64'h0001_0001;
    return v[31:0];
  endfunction

  // ---------------- stimulus driver ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid = 0; in_mem_read = 0; in_mem_write = 0; in_size = 2'd0; in_signed = 0;
    in_addr = '0; in_store_data = '0; in_reg_wen = 0; in_rd_addr = '0;
  endtask

  // Drives one instruction, services the memory with an ack after 'delay'
  // REQ cycles, and records what the stage did.
  task automatic run_mem(input bit rd, input bit wr, input logic [1:0] sz, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] sdata, input bit rwen,
                         input logic [3:0] rda, input logic [31:0] rdata, input int delay,
                         output obs_t o);
    bit acc;
    o = '{default: 0};
    in_valid = 1; in_mem_read = rd; in_mem_write = wr; in_size = sz; in_signed = sgn;
    in_addr = addr; in_store_data = sdata; in_reg_wen = rwen; in_rd_addr = rda;
    #1;
    acc = stall_out;
    if (acc) o.stalls = 1;
    o.req_seen = dm_bus.req;
    tick;
    if (acc) begin
      o.addr = dm_bus.addr; o.we = dm_bus.we; o.be = dm_bus.be; o.wdata = dm_bus.wdata;
      o.stable = 1;
      for (int k = 1; k <= 64; k++) begin
        if (stall_out) o.stalls++;
        if (dm_bus.req !== 1'b1 || dm_bus.addr !== o.addr || dm_bus.we !== o.we ||
            dm_bus.be !== o.be || dm_bus.wdata !== o.wdata) o.stable = 0;
        if (k >= delay) begin
          dm_bus.ack = 1; dm_bus.rdata = rdata;
          tick;
          dm_bus.ack = 0; dm_bus.rdata = $urandom;
          break;
        end
        tick;
      end
    end
    o.wen = wb_wen; o.wdat = wb_wdata; o.rda = wb_rd_addr;
    o.done_stall = stall_out; o.done_req = dm_bus.req;
    o.errs += int'(err_misalign);
    idle_inputs();
    tick;
    o.errs += int'(err_misalign);
    o.wen_after = wb_wen;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    idle_inputs();
    dm_bus.ack = 0; dm_bus.rdata = '0;
    reset_n = 0;
    tick; tick;
    tests++; if (dm_bus.req !== 1'b0) begin fails++; $display("FAIL reset_dm_req got=%b exp=0", dm_bus.req); end
    tests++; if (dm_bus.we !== 1'b0) begin fails++; $display("FAIL reset_dm_we got=%b exp=0", dm_bus.we); end
    tests++; if (wb_wen !== 1'b0) begin fails++; $display("FAIL reset_wb_wen got=%b exp=0", wb_wen); end
    tests++; if (err_misalign !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err_misalign); end
    tests++; if (wb_rd_addr !== 4'd0) begin fails++; $display("FAIL reset_rd_addr got=%h exp=0", wb_rd_addr); end
    tests++; if (wb_wdata !== 32'd0) begin fails++; $display("FAIL reset_wdata got=%h exp=0", wb_wdata); end
    tests++; if (stall_out !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", stall_out); end
    reset_n = 1;
    tick;
  endtask

  task automatic test_alu;
    obs_t o;
    run_mem(0, 0, 2'd2, 0, 32'h40, 32'h0, 1, 4'd3, 32'h0, 1, o);
    tests++; if (o.stalls != 0) begin fails++; $display("FAIL alu_stall got=%0d exp=0", o.stalls); end
    tests++; if (o.wen !== 1'b1) begin fails++; $display("FAIL alu_wen got=%b exp=1", o.wen); end
    tests++; if (o.wdat !== 32'h40) begin fails++; $display("FAIL alu_wdata got=%h exp=00000040", o.wdat); end
    tests++; if (o.rda !== 4'd3) begin fails++; $display("FAIL alu_rd got=%h exp=3", o.rda); end
  endtask

  task automatic test_signed_byte_load;
    obs_t o;
    run_mem(1, 0, 2'd0, 1, 32'h103, 32'h0, 1, 4'd5, 32'h80FF_0000, 3, o);
    tests++; if (o.addr !== 32'h100) begin fails++; $display("FAIL sbl_addr got=%h exp=00000100", o.addr); end
    tests++; if (o.stalls != 4) begin fails++; $display("FAIL sbl_stalls got=%0d exp=4", o.stalls); end
    tests++; if (o.wdat !== 32'hFFFF_FF80) begin fails++; $display("FAIL sbl_wdata got=%h exp=ffffff80", o.wdat); end
    tests++; if (o.wen !== 1'b1 || o.rda !== 4'd5) begin fails++; $display("FAIL sbl_wen got=%b/%h exp=1/5", o.wen, o.rda); end
    tests++; if (o.done_stall !== 1'b0 || o.done_req !== 1'b0) begin fails++; $display("FAIL sbl_done got=stall%b req%b exp=0/0", o.done_stall, o.done_req); end
    tests++; if (!o.stable || o.we !== 1'b0) begin fails++; $display("FAIL sbl_hold got=stable%0d we%b exp=1/0", o.stable, o.we); end
  endtask

  task automatic test_half_store;
    obs_t o;
    run_mem(0, 1, 2'd1, 0, 32'h202, 32'h0000_ABCD, 1, 4'd7, 32'h0, 2, o);
    tests++; if (o.be !== 4'b1100) begin fails++; $display("FAIL hs_be got=%b exp=1100", o.be); end
    tests++; if (o.wdata !== 32'hABCD_ABCD) begin fails++; $display("FAIL hs_wdata got=%h exp=abcdabcd", o.wdata); end
    tests++; if (o.we !== 1'b1) begin fails++; $display("FAIL hs_we got=%b exp=1", o.we); end
    tests++; if (o.wen !== 1'b0) begin fails++; $display("FAIL hs_wen got=%b exp=0", o.wen); end
  endtask

  task automatic test_misaligned;
    obs_t o;
    run_mem(1, 0, 2'd2, 0, 32'h101, 32'h0, 1, 4'd2, 32'h0, 1, o);
    tests++; if (o.errs != 1) begin fails++; $display("FAIL mis_err got=%0d exp=1", o.errs); end
    tests++; if (o.req_seen || o.stalls != 0) begin fails++; $display("FAIL mis_req got=req%0d stall%0d exp=0/0", o.req_seen, o.stalls); end
    tests++; if (o.wen !== 1'b0) begin fails++; $display("FAIL mis_wen got=%b exp=0", o.wen); end
  endtask

  task automatic test_read_write_both;
    obs_t o;
    run_mem(1, 1, 2'd0, 0, 32'h301, 32'h0000_005A, 1, 4'd9, 32'h1234_5678, 1, o);
    tests++; if (o.we !== 1'b1 || o.be !== 4'b0010) begin fails++; $display("FAIL rw_store got=we%b be%b exp=1/0010", o.we, o.be); end
    tests++; if (o.wen !== 1'b0) begin fails++; $display("FAIL rw_wen got=%b exp=0", o.wen); end
  endtask

  task automatic test_reset_in_req;
    in_valid = 1; in_mem_read = 1; in_mem_write = 0; in_size = 2'd2; in_signed = 0;
    in_addr = 32'h300; in_reg_wen = 1; in_rd_addr = 4'd6;
    tick;
    tests++; if (dm_bus.req !== 1'b1) begin fails++; $display("FAIL rir_req_before got=%b exp=1", dm_bus.req); end
    reset_n = 0;
    #1;
    tests++; if (dm_bus.req !== 1'b0) begin fails++; $display("FAIL rir_req_async got=%b exp=0", dm_bus.req); end
    idle_inputs();
    dm_bus.ack = 1; dm_bus.rdata = 32'hDEAD_BEEF;
    #1;
    tests++; if (stall_out !== 1'b0) begin fails++; $display("FAIL rir_stall got=%b exp=0", stall_out); end
    tick;
    reset_n = 1;
    tick;
    dm_bus.ack = 0;
    tests++; if (dm_bus.req !== 1'b0 || wb_wen !== 1'b0) begin fails++; $display("FAIL rir_late_ack got=req%b wen%b exp=0/0", dm_bus.req, wb_wen); end
    tick;
    tests++; if (wb_wen !== 1'b0 || stall_out !== 1'b0) begin fails++; $display("FAIL rir_idle got=wen%b stall%b exp=0/0", wb_wen, stall_out); end
  endtask

  task automatic test_random;
    obs_t o;
    for (int i = 0; i < 40; i++) begin
      int kind = int'($urandom_range(0, 3));
      bit rd = (kind == 1) || (kind == 3);
      bit wr = (kind == 2) || (kind == 3);
      logic [1:0] sz = 2'($urandom_range(0, 3));
      bit sgn = 1'($urandom_range(0, 1));
      logic [31:0] addr = $urandom;
      logic [31:0] sdata = $urandom;
      logic [31:0] rdata = $urandom;
      bit rwen = 1'($urandom_range(0, 1));
      logic [3:0] rda = 4'($urandom_range(0, 15));
      int delay = int'($urandom_range(1, 4));
      bit is_mem, mis, acc, exp_wen;
      if ($urandom_range(0, 1) == 1) addr = addr - 32'(longint'(addr) % nbytes(sz));
      is_mem = rd || wr;
      mis = is_mem && ref_mis(sz, addr);
      acc = is_mem && !mis;
      exp_wen = !mis && !wr && rwen;
      run_mem(rd, wr, sz, sgn, addr, sdata, rwen, rda, rdata, delay, o);
      tests++;
      if (o.stalls != (acc ? delay + 1 : 0) || o.errs != (mis ? 1 : 0))
        begin fails++; $display("FAIL rnd%0d_ctl got=stall%0d err%0d exp=stall%0d err%0d", i, o.stalls, o.errs, acc ? delay + 1 : 0, mis ? 1 : 0); end
      tests++;
      if (o.wen !== exp_wen || o.wen_after !== 1'b0)
        begin fails++; $display("FAIL rnd%0d_wen got=%b/%b exp=%b/0", i, o.wen, o.wen_after, exp_wen); end
      if (acc) begin
        tests++;
        if (o.addr !== {addr[31:2], 2'b00} || o.we !== wr || o.be !== ref_be(sz, addr) || !o.stable)
          begin fails++; $display("FAIL rnd%0d_bus got=a%h we%b be%b st%0d exp=a%h we%b be%b st1", i, o.addr, o.we, o.be, o.stable, {addr[31:2], 2'b00}, wr, ref_be(sz, addr)); end
        if (wr) begin
          tests++;
          if (o.wdata !== ref_wdata(sz, sdata)) begin fails++; $display("FAIL rnd%0d_st got=%h exp=%h", i, o.wdata, ref_wdata(sz, sdata)); end
        end
      end
      if (exp_wen) begin
        logic [31:0] exp_d = is_mem ? ref_load(sz, sgn, addr, rdata) : addr;
        tests++;
        if (o.wdat !== exp_d || o.rda !== rda) begin fails++; $display("FAIL rnd%0d_wb got=%h/%h exp=%h/%h", i, o.wdat, o.rda, exp_d, rda); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_signed_byte_load();
    test_half_store();
    test_misaligned();
    test_read_write_both();
    test_reset_in_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
